// File: rtl/vga_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_coord_gen
// Description : Maps raw VGA sync counters to clamped active-area pixel
//               coordinates with active/line/frame strobes, power-of-two
//               downscaling, tile decomposition and configurable latency.
//               Optional frame counter enabled by VGA_COORD_FRAME_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_coord_gen #(
    parameter int CNT_W       = 10,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 0,
    parameter int TILE_SHIFT  = 3,
    parameter int LATENCY     = 2
`ifdef VGA_COORD_FRAME_CNT_EN
   ,parameter int FRAME_W     = 8
`endif
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [CNT_W-1:0]                           hcount,
    input  logic [CNT_W-1:0]                           vcount,
    output logic [CNT_W-1:0]                           xcoor,
    output logic [CNT_W-1:0]                           ycoor,
    output logic [CNT_W-1:0]                           xs,
    output logic [CNT_W-1:0]                           ys,
    output logic [CNT_W-1:0]                           tile_x,
    output logic [CNT_W-1:0]                           tile_y,
    output logic [((TILE_SHIFT > 0) ? TILE_SHIFT : 1)-1:0] sub_x,
    output logic [((TILE_SHIFT > 0) ? TILE_SHIFT : 1)-1:0] sub_y,
    output logic                                       active,
    output logic                                       line_start,
    output logic                                       frame_start
`ifdef VGA_COORD_FRAME_CNT_EN
   ,output logic [FRAME_W-1:0]                         frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_H_START = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] c_H_END   = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] c_H_MAX   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_V_START = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] c_V_END   = CNT_W'(V_START + V_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_MAX   = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_y;
    logic             w_h_in;
    logic             w_v_in;
    logic             w_active;
    logic             w_line_start;
    logic             w_frame_start;

    // Out-of-window counters clamp to the nearest edge instead of wrapping
    always_comb begin
        w_h_in        = (hcount >= c_H_START) && (hcount < c_H_END);
        w_v_in        = (vcount >= c_V_START) && (vcount < c_V_END);
        w_active      = w_h_in && w_v_in;
        w_line_start  = (hcount == c_H_START) && w_v_in;
        w_frame_start = (hcount == c_H_START) && (vcount == c_V_START);

        if (hcount < c_H_START) begin
            w_x = '0;
        end else if (hcount >= c_H_END) begin
            w_x = c_H_MAX;
        end else begin
            w_x = hcount - c_H_START;
        end

        if (vcount < c_V_START) begin
            w_y = '0;
        end else if (vcount >= c_V_END) begin
            w_y = c_V_MAX;
        end else begin
            w_y = vcount - c_V_START;
        end
    end

    logic [CNT_W-1:0]   r_x [LATENCY];
    logic [CNT_W-1:0]   r_y [LATENCY];
    logic [LATENCY-1:0] r_active;
    logic [LATENCY-1:0] r_line_start;
    logic [LATENCY-1:0] r_frame_start;

    // Stage 0 captures the decoded sample; later stages are pure delay
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            r_active      <= '0;
            r_line_start  <= '0;
            r_frame_start <= '0;
        end else begin
            r_x[0]           <= w_x;
            r_y[0]           <= w_y;
            r_active[0]      <= w_active;
            r_line_start[0]  <= w_line_start;
            r_frame_start[0] <= w_frame_start;
            for (int i = 1; i < LATENCY; i++) begin
                r_x[i]           <= r_x[i-1];
                r_y[i]           <= r_y[i-1];
                r_active[i]      <= r_active[i-1];
                r_line_start[i]  <= r_line_start[i-1];
                r_frame_start[i] <= r_frame_start[i-1];
            end
        end
    end

    assign xcoor       = r_x[LATENCY-1];
    assign ycoor       = r_y[LATENCY-1];
    assign active      = r_active[LATENCY-1];
    assign line_start  = r_line_start[LATENCY-1];
    assign frame_start = r_frame_start[LATENCY-1];

    assign xs     = xcoor >> SCALE_SHIFT;
    assign ys     = ycoor >> SCALE_SHIFT;
    assign tile_x = xs >> TILE_SHIFT;
    assign tile_y = ys >> TILE_SHIFT;

    generate
        if (TILE_SHIFT == 0) begin : g_sub_none
            assign sub_x = '0;
            assign sub_y = '0;
        end else begin : g_sub_mask
            assign sub_x = xs[TILE_SHIFT-1:0];
            assign sub_y = ys[TILE_SHIFT-1:0];
        end
    endgenerate

`ifdef VGA_COORD_FRAME_CNT_EN
    logic [FRAME_W-1:0] r_frame_cnt;

    // Counts the output-aligned pulse, so the pulse cycle still shows the old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_coord_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_coord_gen
// Description : Self-checking bench for vga_coord_gen against a per-sample
//               behavioural model delayed by LATENCY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_coord_gen;

    localparam int CNT_W       = 10;
    localparam int H_START     = 144;
    localparam int H_ACTIVE    = 640;
    localparam int V_START     = 35;
    localparam int V_ACTIVE    = 480;
    localparam int SCALE_SHIFT = 1;
    localparam int TILE_SHIFT  = 3;
    localparam int LATENCY     = 3;
    localparam int FRAME_W     = 2;
    localparam int SUB_W       = (TILE_SHIFT > 0) ? TILE_SHIFT : 1;
    localparam int SS          = 1 << SCALE_SHIFT;
    localparam int TS          = 1 << TILE_SHIFT;
    localparam int OBS_W       = 6 * CNT_W + 2 * SUB_W + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] hcount = '0;
    logic [CNT_W-1:0] vcount = '0;
    logic [CNT_W-1:0] xcoor, ycoor, xs, ys, tile_x, tile_y;
    logic [SUB_W-1:0] sub_x, sub_y;
    logic             active, line_start, frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    vga_coord_gen #(
        .CNT_W       (CNT_W),
        .H_START     (H_START),
        .H_ACTIVE    (H_ACTIVE),
        .V_START     (V_START),
        .V_ACTIVE    (V_ACTIVE),
        .SCALE_SHIFT (SCALE_SHIFT),
        .TILE_SHIFT  (TILE_SHIFT),
        .LATENCY     (LATENCY)
`ifdef VGA_COORD_FRAME_CNT_EN
       ,.FRAME_W     (FRAME_W)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .xcoor       (xcoor),
        .ycoor       (ycoor),
        .xs          (xs),
        .ys          (ys),
        .tile_x      (tile_x),
        .tile_y      (tile_y),
        .sub_x       (sub_x),
        .sub_y       (sub_y),
        .active      (active),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_COORD_FRAME_CNT_EN
       ,.frame_cnt   (frame_cnt)
`endif
    );

`ifndef VGA_COORD_FRAME_CNT_EN
    assign frame_cnt = '0;
`endif

    always #5 clk = ~clk;

    logic [OBS_W-1:0] w_obs;
    assign w_obs = {xcoor, ycoor, xs, ys, tile_x, tile_y, sub_x, sub_y,
                    active, line_start, frame_start};

    typedef struct packed {
        int   x;
        int   y;
        logic a;
        logic ls;
        logic fs;
    } exp_t;

    exp_t hist [LATENCY];
    int   fc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference decode of a single counter sample from the window rules
    function automatic exp_t model(input int h, input int v);
        exp_t e;
        bit   hin = (h >= H_START) && (h < H_START + H_ACTIVE);
        bit   vin = (v >= V_START) && (v < V_START + V_ACTIVE);
        e.x  = (h < H_START) ? 0 : (hin ? h - H_START : H_ACTIVE - 1);
        e.y  = (v < V_START) ? 0 : (vin ? v - V_START : V_ACTIVE - 1);
        e.a  = hin && vin;
        e.ls = (h == H_START) && vin;
        e.fs = (h == H_START) && (v == V_START);
        return e;
    endfunction

    function automatic logic [OBS_W-1:0] exp_obs();
        exp_t e  = hist[LATENCY-1];
        int   sx = e.x / SS;
        int   sy = e.y / SS;
        return {CNT_W'(e.x), CNT_W'(e.y), CNT_W'(sx), CNT_W'(sy),
                CNT_W'(sx / TS), CNT_W'(sy / TS), SUB_W'(sx % TS), SUB_W'(sy % TS),
                e.a, e.ls, e.fs};
    endfunction

    task automatic step(input int h, input int v, input bit rn);
        bit prev_fs = hist[LATENCY-1].fs;
        hcount = CNT_W'(h);
        vcount = CNT_W'(v);
        rst_n  = rn;
        @(posedge clk);
        #1;
        if (!rn) begin
            for (int i = 0; i < LATENCY; i++) hist[i] = '0;
            fc = 0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = model(h, v);
            if (prev_fs) fc = (fc + 1) % (1 << FRAME_W);
        end
    endtask

    task automatic test_reset();
        step(H_START, V_START, 1'b1);
        step(300, 100, 1'b0);
        if (w_obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", w_obs);
        end
        checks++;
`ifdef VGA_COORD_FRAME_CNT_EN
        if (frame_cnt !== '0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
        checks++;
`endif
    endtask

    task automatic test_first_pixel();
        step(H_START, V_START, 1'b1);
        repeat (LATENCY - 1) step(0, 0, 1'b1);
        if ({xcoor, ycoor, active, line_start, frame_start} !== {CNT_W'(0), CNT_W'(0), 3'b111}) begin
            errors++;
            $display("FAIL first_pixel: got x=%0d y=%0d a/ls/fs=%b%b%b expected 0 0 111",
                     xcoor, ycoor, active, line_start, frame_start);
        end
        checks++;
        step(0, 0, 1'b1);
        if (frame_start !== 1'b0 || line_start !== 1'b0) begin
            errors++;
            $display("FAIL strobe_one_cycle: got ls=%b fs=%b expected 0 0", line_start, frame_start);
        end
        checks++;
    endtask

    task automatic test_h_boundaries();
        int hs [4] = '{H_START - 1, H_START, H_START + H_ACTIVE - 1, H_START + H_ACTIVE};
        int xe [4] = '{0, 0, H_ACTIVE - 1, H_ACTIVE - 1};
        bit ae [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            repeat (LATENCY) step(hs[k], 100, 1'b1);
            if (xcoor !== CNT_W'(xe[k]) || active !== ae[k] || ycoor !== CNT_W'(65)) begin
                errors++;
                $display("FAIL h_boundary h=%0d: got x=%0d y=%0d a=%b expected x=%0d y=65 a=%b",
                         hs[k], xcoor, ycoor, active, xe[k], ae[k]);
            end
            checks++;
            if (w_obs !== exp_obs()) begin
                errors++;
                $display("FAIL h_boundary_model h=%0d: got %h expected %h", hs[k], w_obs, exp_obs());
            end
            checks++;
        end
    endtask

    task automatic test_v_clamp();
        int vs [2] = '{20, 600};
        int ye [2] = '{0, V_ACTIVE - 1};
        for (int k = 0; k < 2; k++) begin
            repeat (LATENCY) step(300, vs[k], 1'b1);
            if (ycoor !== CNT_W'(ye[k]) || xcoor !== CNT_W'(156) || active !== 1'b0) begin
                errors++;
                $display("FAIL v_clamp v=%0d: got x=%0d y=%0d a=%b expected x=156 y=%0d a=0",
                         vs[k], xcoor, ycoor, active, ye[k]);
            end
            checks++;
        end
    endtask

    task automatic test_scale_tile();
        step(H_START + 37, V_START + 50, 1'b1);
        repeat (LATENCY - 1) step(0, 0, 1'b1);
        if ({xs, ys, tile_x, sub_x, tile_y, sub_y} !==
            {CNT_W'(18), CNT_W'(25), CNT_W'(2), SUB_W'(2), CNT_W'(3), SUB_W'(1)}) begin
            errors++;
            $display("FAIL scale_tile: got xs=%0d ys=%0d tx=%0d sx=%0d ty=%0d sy=%0d expected 18 25 2 2 3 1",
                     xs, ys, tile_x, sub_x, tile_y, sub_y);
        end
        checks++;
    endtask

    task automatic test_reset_mid_line();
        for (int i = 0; i < 5; i++) step(200 + i, 100, 1'b1);
        step(250, 100, 1'b0);
        if (w_obs !== '0) begin
            errors++;
            $display("FAIL midreset_edge: got %h expected 0", w_obs);
        end
        checks++;
        for (int i = 0; i < LATENCY - 1; i++) begin
            step(300 + i, 100, 1'b1);
            if (w_obs !== '0) begin
                errors++;
                $display("FAIL midreset_flush %0d: got %h expected 0", i, w_obs);
            end
            checks++;
        end
        step(400, 100, 1'b1);
        if (xcoor !== CNT_W'(156) || ycoor !== CNT_W'(65) || active !== 1'b1) begin
            errors++;
            $display("FAIL midreset_first: got x=%0d y=%0d a=%b expected 156 65 1", xcoor, ycoor, active);
        end
        checks++;
    endtask

    task automatic test_frame_cnt();
`ifdef VGA_COORD_FRAME_CNT_EN
        int seq [5] = '{1, 2, 3, 0, 1};
        int n = 0;
        bit prev_fs;
        step(0, 0, 1'b0);
        prev_fs = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 0 && k < 20) step(H_START, V_START, 1'b1);
            else step(0, 0, 1'b1);
            if (frame_cnt !== FRAME_W'(fc)) begin
                errors++;
                $display("FAIL frame_cnt_model step %0d: got %0d expected %0d", k, frame_cnt, fc);
            end
            checks++;
            if (prev_fs && n < 5) begin
                if (frame_cnt !== FRAME_W'(seq[n])) begin
                    errors++;
                    $display("FAIL frame_cnt_seq %0d: got %0d expected %0d", n, frame_cnt, seq[n]);
                end
                checks++;
                n++;
            end
            prev_fs = frame_start;
        end
        if (n !== 5) begin
            errors++;
            $display("FAIL frame_cnt_pulses: got %0d expected 5", n);
        end
        checks++;
`endif
    endtask

    task automatic test_random();
        int hb [4] = '{H_START - 1, H_START, H_START + H_ACTIVE - 1, H_START + H_ACTIVE};
        int vb [4] = '{V_START - 1, V_START, V_START + V_ACTIVE - 1, V_START + V_ACTIVE};
        for (int k = 0; k < 600; k++) begin
            int h = ($urandom_range(0, 3) == 0) ? hb[$urandom_range(0, 3)] : int'($urandom_range(0, 1023));
            int v = ($urandom_range(0, 3) == 0) ? vb[$urandom_range(0, 3)] : int'($urandom_range(0, 1023));
            bit rn = ($urandom_range(0, 59) != 0);
            step(h, v, rn);
            if (w_obs !== exp_obs()) begin
                errors++;
                $display("FAIL random %0d (h=%0d v=%0d rn=%b): got %h expected %h", k, h, v, rn, w_obs, exp_obs());
            end
            checks++;
`ifdef VGA_COORD_FRAME_CNT_EN
            if (frame_cnt !== FRAME_W'(fc)) begin
                errors++;
                $display("FAIL random_frame_cnt %0d: got %0d expected %0d", k, frame_cnt, fc);
            end
            checks++;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < LATENCY; i++) hist[i] = '0;
        test_reset();
        test_first_pixel();
        test_h_boundaries();
        test_v_clamp();
        test_scale_tile();
        test_reset_mid_line();
        test_frame_cnt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_coord_gen.md
Name: vga_coord_gen

Overview:
- Parametrised successor to the VGA coordinate stage. Converts raw sync-generator counters (hcount/vcount) into active-area pixel coordinates.
- Adds an active flag, line/frame start strobes, power-of-two pixel downscaling and tile/sub-tile decomposition.
- Provides a configurable pipeline depth so outputs align with downstream framebuffer/ROM latency.
- Sits between the VGA timing generator and the GPU pixel/tile fetch logic.

Parameters:
- CNT_W, 10, width of hcount/vcount and unscaled coordinates; must hold H_START+H_ACTIVE and V_START+V_ACTIVE.
- H_START, 144, hcount value of first active pixel.
- H_ACTIVE, 640, active pixels per line.
- V_START, 35, vcount value of first active line.
- V_ACTIVE, 480, active lines per frame.
- SCALE_SHIFT, 0, coordinate downscale: scaled = coord >> SCALE_SHIFT (range 0..3).
- TILE_SHIFT, 3, log2 of tile edge in scaled pixels (range 0..5).
- LATENCY, 2, input-to-output delay in clocks (range 1..4).
- FRAME_W, 8, frame counter width (only with the optional feature).

Ports:
- clk  in  1  system/pixel clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- hcount  in  CNT_W  raw horizontal counter.
- vcount  in  CNT_W  raw vertical counter.
- xcoor  out  CNT_W  unscaled active x, clamped.
- ycoor  out  CNT_W  unscaled active y, clamped.
- xs  out  CNT_W  xcoor >> SCALE_SHIFT.
- ys  out  CNT_W  ycoor >> SCALE_SHIFT.
- tile_x  out  CNT_W  xs >> TILE_SHIFT.
- tile_y  out  CNT_W  ys >> TILE_SHIFT.
- sub_x  out  max(TILE_SHIFT,1)  xs low TILE_SHIFT bits (0 when TILE_SHIFT=0).
- sub_y  out  max(TILE_SHIFT,1)  ys low TILE_SHIFT bits (0 when TILE_SHIFT=0).
- active  out  1  pixel inside both active windows.
- line_start  out  1  one-cycle pulse at first active pixel of each active line.
- frame_start  out  1  one-cycle pulse at first active pixel of frame.
- frame_cnt  out  FRAME_W  frame counter (present only with FRAME_CNT_EN).

Behaviour:
- Reset: synchronous. A rising edge with rst_n=0 clears every pipeline register, so all outputs read 0 after that edge.
- Reset mid-frame: pipeline is flushed with no stale valid data. Only inputs applied from the first edge with rst_n=1 propagate; the first valid output appears LATENCY edges later.
- Stage 1 (registered), horizontal; all compares unsigned at CNT_W:
  - hcount < H_START gives x = 0.
  - hcount >= H_START+H_ACTIVE gives x = H_ACTIVE-1.
  - Otherwise x = hcount - H_START (CNT_W-bit subtract).
- Stage 1, vertical: same rule with V_START/V_ACTIVE.
- h_in is the in-window condition for hcount; v_in likewise for vcount.
- active = h_in & v_in.
- line_start = (hcount == H_START) & v_in.
- frame_start = (hcount == H_START) & (vcount == V_START).
- Scaled, tile and sub fields derive combinationally from the registered x/y of the last stage (pure shifts/masks, no extra latency).
- Stages 2..LATENCY: plain delay registers carrying x, y, active, line_start, frame_start. All outputs are mutually aligned with total latency exactly LATENCY clocks.
- Outside the active window, coordinates are clamped, not wrapped. Consumers qualify with active.
- Boundaries:
  - hcount = H_START-1 gives x=0, active=0.
  - hcount = H_START gives x=0, active=1 (if v_in).
  - hcount = H_START+H_ACTIVE-1 gives x=H_ACTIVE-1, active=1.
  - hcount = H_START+H_ACTIVE gives x=H_ACTIVE-1, active=0.
- frame_start implies line_start in the same cycle.
- Input counters are not checked for monotonicity. Arbitrary jumps are handled per-sample with no internal state except frame_cnt.

Optional Feature:
- Macro VGA_COORD_FRAME_CNT_EN.
- Defined:
  - frame_cnt port exists.
  - FRAME_W-bit register, reset to 0, increments by 1 on each cycle where the output frame_start is 1.
  - Wraps from 2^FRAME_W-1 to 0.
  - Value updates on the edge after the frame_start output, so frame_start cycle k shows the old count.
- Undefined: no frame_cnt port and no counter logic; all other behaviour identical.

Test Plan:
- Defaults, LATENCY=2. Drive hcount=144, vcount=35 at cycle 0 -> at cycle 2: xcoor=0, ycoor=0, active=1, line_start=1, frame_start=1.
- Defaults. hcount sweep 143/144/783/784 at vcount=100 -> xcoor 0/0/639/639; active 0/1/1/0; ycoor=65.
- Defaults. vcount=20 and vcount=600 at hcount=300 -> ycoor=0 and 479 respectively; active=0; xcoor=156.
- SCALE_SHIFT=1, TILE_SHIFT=3. hcount=144+37, vcount=35+50 -> xs=18, ys=25, tile_x=2, sub_x=2, tile_y=3, sub_y=1.
- LATENCY=3. Stream valid pixels, assert rst_n=0 for one edge mid-line, release -> outputs 0 for the reset edge plus the next 2 edges; the first post-reset sample appears 3 edges after release.
- With VGA_COORD_FRAME_CNT_EN, FRAME_W=2. Run 5 frame_start events -> frame_cnt sequence 1,2,3,0,1 (each value seen one cycle after its pulse).
